mem_access_ctrl: RTL and testbench

Sequencer and two-port arbiter for the memory subsystem (MAR, MDR, 512×32 RAM). It accepts single-word read/write requests from the instruction-fetch unit (port F) and the load/store unit (port D). It grants one request at a time with round-robin priority and drives the MAR load, RAM read/write and MDR load strobes in the fixed order the subsystem requires. It returns read data and a one-cycle acknowledge to the granted requester.

---
 rtl/mem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer and two-port round-robin arbiter.
// Grants one single-word read/write from the fetch (F) or load/store (D) port at a time.
// It then drives the MAR load, RAM access and MDR capture strobes in a fixed order,
// and returns a one-cycle acknowledge to the granted port. All outputs are registered.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mar_load,
    output logic [ADDR_W-1:0] mar_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mdr_load,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAccess,
        StCapture,
        StResp
    } state_e;

    localparam logic [2:0] LatM1 = 3'(RAM_LAT - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_d_q, last_d_d;   // 1: last grant went to D
    logic              port_d_q, port_d_d;   // 1: transaction in flight belongs to D
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_d;

    logic              f_ack_n, d_ack_n, mar_load_n, mem_read_n, mem_write_n;
    logic              mdr_load_n, busy_n;
    logic [ADDR_W-1:0] mar_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, rdata_n;

    // Next-state, arbitration and request latching.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d_d = last_d_q;
        port_d_d = port_d_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        grant_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (f_req || d_req) begin
                    // D wins when alone, or on a tie when F was granted last.
                    grant_d  = d_req && (!f_req || !last_d_q);
                    port_d_d = grant_d;
                    last_d_d = grant_d;
                    we_d     = grant_d ? d_we : 1'b0;
                    addr_d   = grant_d ? d_addr : f_addr;
                    wdata_d  = grant_d ? d_wdata : '0;
                    state_d  = StAddr;
                end
            end
            StAddr: begin
                cnt_d   = LatM1;
                state_d = StAccess;
            end
            StAccess: begin
                if (cnt_q == 3'd0) begin
                    state_d = we_q ? StResp : StCapture;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StCapture: state_d = StResp;
            StResp:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output decode from the upcoming state so every strobe is a flop output.
    always_comb begin
        mar_load_n  = (state_d == StAddr);
        mar_addr_n  = (state_d == StAddr) ? addr_d : mar_addr;
        mem_read_n  = (state_d == StAccess) && !we_d;
        mem_write_n = (state_d == StAccess) && we_d;
        mem_wdata_n = mem_write_n ? wdata_d : mem_wdata;
        mdr_load_n  = (state_d == StCapture);
        f_ack_n     = (state_d == StResp) && !port_d_d;
        d_ack_n     = (state_d == StResp) && port_d_d;
        busy_n      = (state_d != StIdle);
        rdata_n     = (state_q == StCapture) ? mem_rdata : rdata;
    end

    // State, latched request and registered outputs with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            last_d_q  <= 1'b1;
            port_d_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            mar_load  <= 1'b0;
            mar_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            mdr_load  <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            port_d_q  <= port_d_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f_ack     <= f_ack_n;
            d_ack     <= d_ack_n;
            mar_load  <= mar_load_n;
            mar_addr  <= mar_addr_n;
            mem_read  <= mem_read_n;
            mem_write <= mem_write_n;
            mem_wdata <= mem_wdata_n;
            mdr_load  <= mdr_load_n;
            busy      <= busy_n;
            rdata     <= rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance at RAM_LAT=1, one at RAM_LAT=3,
// each with its own MAR/RAM model. Inputs are shared between the two instances.
module tb_mem_access_ctrl;

    logic        clock = 1'b0;
    logic        clear;
    logic        f_req, d_req, d_we;
    logic [8:0]  f_addr, d_addr;
    logic [31:0] d_wdata;

    logic        f_ack1, d_ack1, mar_load1, mem_read1, mem_write1, mdr_load1, busy1;
    logic [8:0]  mar_addr1;
    logic [31:0] rdata1, mem_wdata1, mem_rdata1;
    logic        f_ack2, d_ack2, mar_load2, mem_read2, mem_write2, mdr_load2, busy2;
    logic [8:0]  mar_addr2;
    logic [31:0] rdata2, mem_wdata2, mem_rdata2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(1)) dut1 (
        .clock(clock), .clear(clear),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack1),
        .rdata(rdata1), .mar_load(mar_load1), .mar_addr(mar_addr1),
        .mem_read(mem_read1), .mem_write(mem_write1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .mdr_load(mdr_load1), .busy(busy1)
    );

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(3)) dut2 (
        .clock(clock), .clear(clear),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack2),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack2),
        .rdata(rdata2), .mar_load(mar_load2), .mar_addr(mar_addr2),
        .mem_read(mem_read2), .mem_write(mem_write2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mdr_load(mdr_load2), .busy(busy2)
    );

    // MAR + RAM models; read data appears the cycle after a mem_read cycle.
    logic [31:0] ram1 [0:511];
    logic [31:0] ram2 [0:511];
    logic [8:0]  mar1, mar2;
    logic        pl_we, pl_sel;
    logic [8:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge clock) begin
        if (mar_load1) mar1 <= mar_addr1;
        if (mem_read1) mem_rdata1 <= ram1[mar1];
        if (mem_write1) ram1[mar1] <= mem_wdata1;
        if (mar_load2) mar2 <= mar_addr2;
        if (mem_read2) mem_rdata2 <= ram2[mar2];
        if (mem_write2) ram2[mar2] <= mem_wdata2;
        if (pl_we && !pl_sel) ram1[pl_addr] <= pl_data;
        if (pl_we && pl_sel) ram2[pl_addr] <= pl_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic preload(input bit sel, input logic [8:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_we = 1'b0;
    endtask

    task automatic check_quiet1(input string name);
        check({name, "_strobes"}, 32'({f_ack1, d_ack1, mar_load1, mem_read1, mem_write1,
                                       mdr_load1, busy1}), 32'd0);
        check({name, "_rdata"}, rdata1, 32'd0);
        check({name, "_mar_addr"}, 32'(mar_addr1), 32'd0);
        check({name, "_mem_wdata"}, mem_wdata1, 32'd0);
    endtask

    // One transaction on instance sel, starting at a negedge with the DUT in IDLE.
    task automatic run_txn(input bit sel, input bit is_d, input bit we, input logic [8:0] addr,
                           input logic [31:0] wd, input int lat, input logic [31:0] exp_rd,
                           input string tag);
        int mar_cyc = -1, acc_first = -1, acc_cnt = 0, wrong_kind = 0, mdr_cyc = -1;
        int ack_cyc = -1, busy_bad = 0, excl_bad = 0, other_ack = 0;
        logic [8:0]  mar_seen = '0;
        logic [31:0] rd_seen = '0;
        logic ml, mr, mw, mdr, by, my_ack, oth;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        for (int k = 1; k <= 15 && ack_cyc < 0; k++) begin
            @(negedge clock);
            ml  = sel ? mar_load2 : mar_load1;
            mr  = sel ? mem_read2 : mem_read1;
            mw  = sel ? mem_write2 : mem_write1;
            mdr = sel ? mdr_load2 : mdr_load1;
            by  = sel ? busy2 : busy1;
            my_ack = is_d ? (sel ? d_ack2 : d_ack1) : (sel ? f_ack2 : f_ack1);
            oth    = is_d ? (sel ? f_ack2 : f_ack1) : (sel ? d_ack2 : d_ack1);
            if (ml) begin
                if (mar_cyc < 0) mar_cyc = k;
                mar_seen = sel ? mar_addr2 : mar_addr1;
            end
            if (mr || mw) begin
                if (acc_first < 0) acc_first = k;
                acc_cnt++;
                if (mw != we) wrong_kind++;
            end
            if (mdr) mdr_cyc = k;
            if (int'(ml) + int'(mr) + int'(mw) + int'(mdr) > 1) excl_bad++;
            if (!by) busy_bad++;
            if (oth) other_ack++;
            if (my_ack) begin
                ack_cyc = k;
                rd_seen = sel ? rdata2 : rdata1;
                f_req = 1'b0;
                d_req = 1'b0;
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        check({tag, "_mar_cycle"}, 32'(mar_cyc), 32'd1);
        check({tag, "_mar_addr"}, 32'(mar_seen), 32'(addr));
        check({tag, "_access_first"}, 32'(acc_first), 32'd2);
        check({tag, "_access_count"}, 32'(acc_cnt), 32'(lat));
        check({tag, "_access_kind"}, 32'(wrong_kind), 32'd0);
        check({tag, "_mdr_cycle"}, 32'(mdr_cyc), we ? 32'hFFFF_FFFF : 32'(2 + lat));
        check({tag, "_ack_cycle"}, 32'(ack_cyc), we ? 32'(2 + lat) : 32'(3 + lat));
        if (!we) check({tag, "_rdata"}, rd_seen, exp_rd);
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        check({tag, "_strobe_excl"}, 32'(excl_bad), 32'd0);
        check({tag, "_other_ack"}, 32'(other_ack), 32'd0);
        @(negedge clock);
        check({tag, "_ack_width"},
              32'(is_d ? (sel ? d_ack2 : d_ack1) : (sel ? f_ack2 : f_ack1)), 32'd0);
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int acks_f [$];
        int acks_cyc [$];
        logic [31:0] acks_rd [$];
        int excl_bad, wide_ack, no_ack;
        logic prev_ack;

        vecs[0] = '{1'b0, 1'b0, 9'h0A5, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
        vecs[3] = '{1'b0, 1'b0, 9'h1FF, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 1'b1, 9'h000, 32'hA5A5A5A5, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 9'h000, 32'h0,        32'hA5A5A5A5};

        clear = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(negedge clock);
        preload(1'b0, 9'h0A5, 32'hDEADBEEF);
        preload(1'b0, 9'h011, 32'h11111111);
        preload(1'b0, 9'h022, 32'h22222222);
        preload(1'b1, 9'h0A5, 32'hCAFEF00D);

        // Clear held with both requests pending: outputs stay at reset values.
        f_req = 1'b1; d_req = 1'b1; f_addr = 9'h011; d_addr = 9'h022; d_we = 1'b0;
        @(negedge clock);
        check_quiet1("reset_c1");
        @(negedge clock);
        check_quiet1("reset_c2");
        clear = 1'b0;

        // Continuous contention: grants alternate F, D, F, D on a 5-cycle read period.
        excl_bad = 0; wide_ack = 0; prev_ack = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clock);
            if (k == 1) check("first_grant_addr", 32'(mar_addr1), 32'h011);
            if (int'(mar_load1) + int'(mem_read1) + int'(mem_write1) + int'(mdr_load1) > 1)
                excl_bad++;
            if (prev_ack && (f_ack1 || d_ack1)) wide_ack++;
            prev_ack = f_ack1 || d_ack1;
            if (f_ack1 || d_ack1) begin
                acks_f.push_back(int'(f_ack1));
                acks_cyc.push_back(k);
                acks_rd.push_back(rdata1);
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clock);
        check("cont_ack_count", 32'(acks_f.size()), 32'd4);
        if (acks_f.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("cont_order_%0d", i), 32'(acks_f[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("cont_cycle_%0d", i), 32'(acks_cyc[i]), 32'(4 + 5 * i));
                check($sformatf("cont_rdata_%0d", i), acks_rd[i],
                      (i % 2 == 0) ? 32'h11111111 : 32'h22222222);
            end
        end
        check("cont_strobe_excl", 32'(excl_bad), 32'd0);
        check("cont_ack_width", 32'(wide_ack), 32'd0);

        // Table of single transactions on the RAM_LAT=1 instance.
        for (int i = 0; i < 6; i++) begin
            run_txn(1'b0, vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata, 1,
                    vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Clear during the ACCESS cycle of a write drops the transaction.
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'h050; d_wdata = 32'h77777777;
        @(negedge clock);
        @(negedge clock);
        check("midop_in_access", 32'(mem_write1), 32'd1);
        clear = 1'b1; d_req = 1'b0;
        @(negedge clock);
        check_quiet1("midop_after_clear");
        clear = 1'b0;
        no_ack = 0;
        repeat (3) begin
            @(negedge clock);
            if (d_ack1 || f_ack1 || busy1) no_ack++;
        end
        check("midop_no_ack", 32'(no_ack), 32'd0);
        run_txn(1'b0, 1'b0, 1'b0, 9'h0A5, 32'h0, 1, 32'hDEADBEEF, "midop_retry");

        // RAM_LAT=3 read on the second instance, starting from a cleared state.
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        run_txn(1'b1, 1'b0, 1'b0, 9'h0A5, 32'h0, 3, 32'hCAFEF00D, "lat3_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
